// File: rtl/down_timer.sv
// down_timer: loadable, prescaled down-counting timer.
// A load over the valid/ready handshake starts a countdown that decrements
// once every (div+1) clocks. Reaching the terminal count produces a one-cycle
// tick, then either reloads (periodic) or returns to IDLE (one-shot).
module down_timer #(
  parameter int WIDTH = 8,
  parameter int PW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic [PW-1:0]    load_div,
  input  logic             load_periodic,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             busy
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic [WIDTH-1:0] reload_reg, reload_next;
  logic [PW-1:0]    div_reg, div_next;
  logic [PW-1:0]    pre_reg, pre_next;
  logic             periodic_reg, periodic_next;
  logic             tick_reg, tick_next;
  logic             busy_reg;

  assign load_ready = (state_reg == IDLE);
  assign count      = count_reg;
  assign tick       = tick_reg;
  assign busy       = busy_reg;

  // State and datapath registers; busy mirrors the RUN state one-for-one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      reload_reg   <= '0;
      div_reg      <= '0;
      pre_reg      <= '0;
      periodic_reg <= 1'b0;
      tick_reg     <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      reload_reg   <= reload_next;
      div_reg      <= div_next;
      pre_reg      <= pre_next;
      periodic_reg <= periodic_next;
      tick_reg     <= tick_next;
      busy_reg     <= (state_next == RUN);
    end
  end

  // Next-state logic: load handling in IDLE; stop > prescale > decrement in RUN.
  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    reload_next   = reload_reg;
    div_next      = div_reg;
    pre_next      = pre_reg;
    periodic_next = periodic_reg;
    tick_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (load_valid) begin
          count_next    = load_value;
          reload_next   = load_value;
          div_next      = load_div;
          periodic_next = load_periodic;
          pre_next      = '0;
          if (load_value != '0) begin
            state_next = RUN;
          end else begin
            // A zero load is already at terminal: tick immediately, stay idle.
            tick_next = 1'b1;
          end
        end
      end

      RUN: begin
        if (stop) begin
          // Abort keeps the current count visible for the controller.
          state_next = IDLE;
          pre_next   = '0;
        end else if (pre_reg == div_reg) begin
          pre_next = '0;
          if (count_reg > WIDTH'(1)) begin
            count_next = count_reg - WIDTH'(1);
          end else begin
            // Terminal count (count is never 0 while running).
            tick_next = 1'b1;
            if (periodic_reg) begin
              count_next = reload_reg;
            end else begin
              count_next = '0;
              state_next = IDLE;
            end
          end
        end else begin
          pre_next = pre_reg + PW'(1);
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: doc/down_timer.md
Name: down_timer

Overview:
- Loadable, prescaled down-counting timer with a terminal-count pulse; the counterpart to the team's free-running up counter.
- A controller loads a count over a valid/ready handshake. The block counts down to zero and pulses tick.
- Operates one-shot or periodic (auto-reload).
- Used as the timeout and periodic-event source for other blocks.

Parameters:
- WIDTH, 8, width of count and load value.
- PW, 4, width of prescale divider field.

Ports:
- clk  input  1  clock.
- rst  input  1  reset: synchronous, active-high.
- load_valid  input  1  load request.
- load_ready  output  1  block can accept a load (high only in IDLE).
- load_value  input  WIDTH  initial/reload count N.
- load_div  input  PW  prescale D; count decrements once every D+1 clk cycles.
- load_periodic  input  1  1 = auto-reload on terminal count, 0 = one-shot.
- stop  input  1  abort a running count.
- count  output  WIDTH  current count value (registered).
- tick  output  1  one-cycle pulse, the cycle after count reaches terminal.
- busy  output  1  high in RUN state.

Behaviour:
- Clock and reset: reset rst, synchronous, active-high; clock clk. All state updates on posedge clk.
- Reset values: count=0, tick=0, busy=0, load_ready=1, state=IDLE. Internal prescale counter pre=0, latched reload=0, div=0, periodic=0.
- States: IDLE, RUN.
- load_ready = (state==IDLE), decoded combinationally from state.
- busy = (state==RUN), registered.
- IDLE: a load is accepted at an edge where load_valid && load_ready (edge E0). At E0:
  - count<=load_value, reload<=load_value, div<=load_div, periodic<=load_periodic, pre<=0.
  - If load_value!=0: state<=RUN.
  - If load_value==0: state stays IDLE, tick=1 for the cycle after E0, count=0, periodic ignored.
- RUN, per edge, priority order stop > decrement:
  - If stop: state<=IDLE, count holds its value, pre<=0, no tick.
  - Else if pre==div: pre<=0 and a decrement event occurs.
  - Else: pre<=pre+1.
- Decrement event with count>1: count<=count-1.
- Decrement event with count==1 (terminal):
  - tick<=1 for exactly one cycle.
  - Periodic: count<=reload, state stays RUN.
  - One-shot: count<=0, state<=IDLE; load_ready high the cycle after the terminal edge.
- Latency: terminal edge is E0+N*(D+1); tick is high in the following cycle.
  - Periodic: tick repeats every N*(D+1) cycles.
- tick is 0 in every cycle where no terminal event (or zero-load) occurred at the preceding edge.
- load_valid in RUN is ignored (load_ready=0). Inputs are not latched and count is unaffected. To retarget a periodic timer, stop first, then load.
- stop in IDLE has no effect. stop at the same edge as a would-be terminal event wins: no tick, count holds 1.
- Arithmetic: count is unsigned WIDTH bits and never wraps below 0. The max load 2^WIDTH-1 is supported. pre is PW bits and compares to the latched div only.
- rst mid-RUN: at that edge all registers return to reset values; tick=0 next cycle even if a terminal event coincided. A load may be accepted at the first non-reset edge.

Test Plan (WIDTH=8, PW=4):
- rst 2 cycles, then load N=3, D=0, one-shot → count 3,2,1,0 on successive cycles; tick high only in the cycle count first reads 0; busy falls and load_ready rises at that same edge.
- Load N=2, D=1, periodic → count reads 2,2,1,1,2,2,1,1…; tick pulses once every 4 cycles, coincident with count reading 2 after each reload; busy stays 1.
- Load N=10, D=0, one-shot; stop sampled at the 5th edge after acceptance → count holds 6, busy=0, tick never asserted; subsequent load N=1 ticks one cycle later.
- Load N=0 → no RUN entry; tick=1 the cycle after acceptance, count=0, load_ready remains 1.
- Periodic N=5, D=0 running; load_valid=1 with load_value=9 for 3 cycles → ignored, count sequence unaffected; then rst mid-count → count=0, tick=0, busy=0, load_ready=1; fresh load N=2 accepted and ticks after 2 cycles.
- Boundary: stop coincident with terminal edge (N=2, D=0, stop at 2nd edge) → no tick, count holds 1, IDLE. Max load 255, D=15 → tick exactly 4080 cycles after acceptance.
